// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master (core / debug port) arbiter in front of a
// single-ported memory with a fixed number of wait states.
//
// Ports
//   CLK, RESET                 clock, async active-high reset
//   CPU_REQ/WE/ADDR/WDATA      core access request
//   DBG_REQ/WE/ADDR/WDATA      debug-port access request
//   DEBUG_MODE_DEBUG           core frozen: CPU requests are not granted
//   MEM_RDATA                  memory read data, valid in the last access cycle
//   MEM_EN/WE/ADDR/WDATA       memory strobe, latched address / write data
//   RDATA                      read data of the last completed read
//   CPU_ACK, DBG_ACK           one-cycle completion pulses
//   CPU_STALL, BUSY            core hold request, access in progress
module mem_bus_arbiter #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CPU_REQ,
  input  logic        CPU_WE,
  input  logic [15:0] CPU_ADDR,
  input  logic [15:0] CPU_WDATA,
  input  logic        DBG_REQ,
  input  logic        DBG_WE,
  input  logic [15:0] DBG_ADDR,
  input  logic [15:0] DBG_WDATA,
  input  logic        DEBUG_MODE_DEBUG,
  input  logic [15:0] MEM_RDATA,
  output logic        MEM_EN,
  output logic        MEM_WE,
  output logic [15:0] MEM_ADDR,
  output logic [15:0] MEM_WDATA,
  output logic [15:0] RDATA,
  output logic        CPU_ACK,
  output logic        DBG_ACK,
  output logic        CPU_STALL,
  output logic        BUSY
);

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [2:0] wcnt;
  logic       owner;     // 1 = debug port owns the current access
  logic       last_dbg;  // last completed access belonged to the debug port
  logic       lat_we;

  logic cpu_elig, dbg_elig, grant, grant_dbg, last_cyc;

  // A requester whose ACK is high this cycle is the one that just finished;
  // masking it lets the other side take the bus in the ACK cycle.
  assign cpu_elig  = CPU_REQ & ~DEBUG_MODE_DEBUG & ~CPU_ACK;
  assign dbg_elig  = DBG_REQ & ~DBG_ACK;
  // Debug wins ties unless it also won the previous access.
  assign grant_dbg = dbg_elig & (~cpu_elig | ~last_dbg);
  assign grant     = (state == IDLE) & (cpu_elig | dbg_elig);
  assign last_cyc  = (state == ACCESS) & (wcnt == 3'd0);

  assign CPU_STALL = CPU_REQ & ~CPU_ACK;

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cpu_elig | dbg_elig) state_nxt = ACCESS;
      ACCESS:  if (wcnt == 3'd0)        state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; asynchronous reset drops MEM_EN at once
  always_comb begin
    MEM_EN = 1'b0;
    MEM_WE = 1'b0;
    BUSY   = 1'b0;
    if (state == ACCESS) begin
      MEM_EN = 1'b1;
      MEM_WE = lat_we;
      BUSY   = 1'b1;
    end
  end

  // Access datapath: latch the winner, count wait states, complete
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wcnt      <= 3'd0;
      owner     <= 1'b0;
      last_dbg  <= 1'b0;
      lat_we    <= 1'b0;
      MEM_ADDR  <= 16'h0000;
      MEM_WDATA <= 16'h0000;
      RDATA     <= 16'h0000;
      CPU_ACK   <= 1'b0;
      DBG_ACK   <= 1'b0;
    end else begin
      CPU_ACK <= 1'b0;
      DBG_ACK <= 1'b0;
      if (grant) begin
        owner     <= grant_dbg;
        lat_we    <= grant_dbg ? DBG_WE    : CPU_WE;
        MEM_ADDR  <= grant_dbg ? DBG_ADDR  : CPU_ADDR;
        MEM_WDATA <= grant_dbg ? DBG_WDATA : CPU_WDATA;
        wcnt      <= WS;
      end else if (last_cyc) begin
        if (!lat_we) RDATA <= MEM_RDATA;
        CPU_ACK  <= ~owner;
        DBG_ACK  <= owner;
        last_dbg <= owner;
      end else if (state == ACCESS) begin
        wcnt <= wcnt - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter. dut uses WAIT_STATES=1, dut0 uses
// WAIT_STATES=0. Completions are checked against per-DUT scoreboards of
// expected {owner, RDATA}; tasks check per-cycle timing inline.
module tb_mem_bus_arbiter;

  typedef struct packed {
    logic        dbg;
    logic [15:0] rdata;
  } exp_t;

  logic        clk, rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_mode;
  logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, mem_rdata;
  logic        mem_en, mem_we, cpu_ack, dbg_ack, cpu_stall, busy;
  logic [15:0] mem_addr, mem_wdata, rdata;

  // WAIT_STATES=0 instance: only the debug port is exercised
  logic        zero1, dbg_req0;
  logic [15:0] zero16, dbg_addr0;
  logic        mem_en0, mem_we0, cpu_ack0, dbg_ack0, cpu_stall0, busy0;
  logic [15:0] mem_addr0, mem_wdata0, rdata0;

  exp_t sb1[$];
  exp_t sb0[$];
  exp_t e1, e0;
  int   n_checks = 0;
  int   n_pass   = 0;

  mem_bus_arbiter #(.WAIT_STATES(1)) dut (
    .CLK(clk), .RESET(rst),
    .CPU_REQ(cpu_req), .CPU_WE(cpu_we), .CPU_ADDR(cpu_addr), .CPU_WDATA(cpu_wdata),
    .DBG_REQ(dbg_req), .DBG_WE(dbg_we), .DBG_ADDR(dbg_addr), .DBG_WDATA(dbg_wdata),
    .DEBUG_MODE_DEBUG(dbg_mode), .MEM_RDATA(mem_rdata),
    .MEM_EN(mem_en), .MEM_WE(mem_we), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata),
    .RDATA(rdata), .CPU_ACK(cpu_ack), .DBG_ACK(dbg_ack),
    .CPU_STALL(cpu_stall), .BUSY(busy)
  );

  mem_bus_arbiter #(.WAIT_STATES(0)) dut0 (
    .CLK(clk), .RESET(rst),
    .CPU_REQ(zero1), .CPU_WE(zero1), .CPU_ADDR(zero16), .CPU_WDATA(zero16),
    .DBG_REQ(dbg_req0), .DBG_WE(zero1), .DBG_ADDR(dbg_addr0), .DBG_WDATA(zero16),
    .DEBUG_MODE_DEBUG(zero1), .MEM_RDATA(mem_rdata),
    .MEM_EN(mem_en0), .MEM_WE(mem_we0), .MEM_ADDR(mem_addr0), .MEM_WDATA(mem_wdata0),
    .RDATA(rdata0), .CPU_ACK(cpu_ack0), .DBG_ACK(dbg_ack0),
    .CPU_STALL(cpu_stall0), .BUSY(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard pops: every ACK must match the oldest expected completion
  always @(negedge clk) begin
    if (cpu_ack === 1'b1 || dbg_ack === 1'b1) begin
      n_checks++;
      if (sb1.size() == 0) begin
        $display("FAIL ack_unexpected: cpu_ack=%b dbg_ack=%b, none expected", cpu_ack, dbg_ack);
      end else begin
        e1 = sb1.pop_front();
        if ({dbg_ack, cpu_ack, rdata} !== {e1.dbg, ~e1.dbg, e1.rdata})
          $display("FAIL ack_sb: got dbg/cpu/rdata=%b/%b/%h exp %b/%b/%h",
                   dbg_ack, cpu_ack, rdata, e1.dbg, ~e1.dbg, e1.rdata);
        else n_pass++;
      end
    end
  end

  always @(negedge clk) begin
    if (cpu_ack0 === 1'b1 || dbg_ack0 === 1'b1) begin
      n_checks++;
      if (sb0.size() == 0) begin
        $display("FAIL ack0_unexpected: cpu_ack=%b dbg_ack=%b, none expected", cpu_ack0, dbg_ack0);
      end else begin
        e0 = sb0.pop_front();
        if ({dbg_ack0, cpu_ack0, rdata0} !== {e0.dbg, ~e0.dbg, e0.rdata})
          $display("FAIL ack0_sb: got dbg/cpu/rdata=%b/%b/%h exp %b/%b/%h",
                   dbg_ack0, cpu_ack0, rdata0, e0.dbg, ~e0.dbg, e0.rdata);
        else n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic test_reset();
    mid();
    n_checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, rdata, cpu_ack, dbg_ack, busy, cpu_stall} !== '0)
      $display("FAIL reset_dut: got en=%b we=%b addr=%h wd=%h rd=%h ack=%b%b busy=%b",
               mem_en, mem_we, mem_addr, mem_wdata, rdata, cpu_ack, dbg_ack, busy);
    else n_pass++;
    n_checks++;
    if ({mem_en0, mem_we0, mem_addr0, mem_wdata0, rdata0, cpu_ack0, dbg_ack0, busy0, cpu_stall0} !== '0)
      $display("FAIL reset_dut0: got en=%b we=%b addr=%h rd=%h busy=%b",
               mem_en0, mem_we0, mem_addr0, rdata0, busy0);
    else n_pass++;
    tick();
    rst = 1'b0;
  endtask

  // CPU read of 0x0120, data valid only in the final access cycle
  task automatic test_cpu_read();
    mem_rdata = 16'h1111;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0120;
    sb1.push_back('{dbg: 1'b0, rdata: 16'hBEEF});
    mid();
    n_checks++;
    if ({mem_en, cpu_stall} !== 2'b01) $display("FAIL rd_c0: en/stall=%b%b exp 01", mem_en, cpu_stall);
    else n_pass++;
    tick(); mid();
    n_checks++;
    if ({mem_en, mem_we, busy, mem_addr} !== {3'b101, 16'h0120})
      $display("FAIL rd_c1: en/we/busy=%b%b%b addr=%h exp 101 0120", mem_en, mem_we, busy, mem_addr);
    else n_pass++;
    tick(); mem_rdata = 16'hBEEF; mid();
    n_checks++;
    if (mem_en !== 1'b1) $display("FAIL rd_c2: en=%b exp 1", mem_en);
    else n_pass++;
    tick(); mem_rdata = 16'h1111; mid();
    n_checks++;
    if ({cpu_ack, mem_en, cpu_stall, rdata} !== {3'b100, 16'hBEEF})
      $display("FAIL rd_c3: ack/en/stall=%b%b%b rdata=%h exp 100 beef", cpu_ack, mem_en, cpu_stall, rdata);
    else n_pass++;
    tick(); cpu_req = 1'b0; mid();
    n_checks++;
    if ({cpu_ack, busy} !== 2'b00) $display("FAIL rd_c4: ack/busy=%b%b exp 00", cpu_ack, busy);
    else n_pass++;
  endtask

  // Both held with LAST_DBG=0: DBG, CPU, DBG with an IDLE cycle between
  localparam logic [15:0] ALT_ADDR [10] = '{16'h0120, 16'h2000, 16'h2000, 16'h2000, 16'h1000,
                                            16'h1000, 16'h1000, 16'h2000, 16'h2000, 16'h2000};
  localparam logic        ALT_EN   [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                                            1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  task automatic test_back_to_back();
    mem_rdata = 16'h7777;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1000;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h2000;
    sb1.push_back('{dbg: 1'b1, rdata: 16'h7777});
    sb1.push_back('{dbg: 1'b0, rdata: 16'h7777});
    sb1.push_back('{dbg: 1'b1, rdata: 16'h7777});
    for (int c = 0; c < 10; c++) begin
      if (c > 0) tick();
      if (c == 9) begin cpu_req = 1'b0; dbg_req = 1'b0; end
      mid();
      n_checks++;
      if ({mem_en, mem_addr} !== {ALT_EN[c], ALT_ADDR[c]})
        $display("FAIL b2b_c%0d: en=%b addr=%h exp %b %h", c, mem_en, mem_addr, ALT_EN[c], ALT_ADDR[c]);
      else n_pass++;
    end
    tick(); mid();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL b2b_end: busy=%b exp 0", busy);
    else n_pass++;
  endtask

  // Debug mode: CPU blocked, DBG write goes through, RDATA untouched
  task automatic test_debug_mode();
    mem_rdata = 16'h3333;
    tick();
    dbg_mode = 1'b1; cpu_req = 1'b1; cpu_addr = 16'h0F00;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0200; dbg_wdata = 16'h5A5A;
    sb1.push_back('{dbg: 1'b1, rdata: 16'h7777});
    for (int c = 1; c <= 2; c++) begin
      tick(); mid();
      n_checks++;
      if ({mem_en, mem_we, cpu_stall, mem_addr, mem_wdata} !== {3'b111, 16'h0200, 16'h5A5A})
        $display("FAIL dm_c%0d: en/we/stall=%b%b%b addr=%h wd=%h exp 111 0200 5a5a",
                 c, mem_en, mem_we, cpu_stall, mem_addr, mem_wdata);
      else n_pass++;
    end
    tick(); dbg_req = 1'b0; mid();
    n_checks++;
    if ({dbg_ack, mem_we, cpu_stall, rdata} !== {3'b101, 16'h7777})
      $display("FAIL dm_c3: ack/we/stall=%b%b%b rdata=%h exp 101 7777", dbg_ack, mem_we, cpu_stall, rdata);
    else n_pass++;
    for (int c = 4; c <= 5; c++) begin
      tick(); mid();
      n_checks++;
      if ({mem_en, cpu_stall} !== 2'b01) $display("FAIL dm_c%0d: en/stall=%b%b exp 01", c, mem_en, cpu_stall);
      else n_pass++;
    end
    tick(); cpu_req = 1'b0; dbg_mode = 1'b0; dbg_we = 1'b0;
  endtask

  // CPU drops REQ in the first access cycle; access still completes once
  task automatic test_drop_req();
    mem_rdata = 16'h4242;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0300;
    sb1.push_back('{dbg: 1'b0, rdata: 16'h4242});
    tick(); cpu_req = 1'b0; mid();
    n_checks++;
    if (mem_en !== 1'b1) $display("FAIL drop_c1: en=%b exp 1", mem_en);
    else n_pass++;
    tick(); tick(); mid();
    n_checks++;
    if ({cpu_ack, rdata} !== {1'b1, 16'h4242}) $display("FAIL drop_c3: ack=%b rdata=%h exp 1 4242", cpu_ack, rdata);
    else n_pass++;
    tick(); mid();
    n_checks++;
    if ({cpu_ack, mem_en} !== 2'b00) $display("FAIL drop_c4: ack/en=%b%b exp 00", cpu_ack, mem_en);
    else n_pass++;
  endtask

  // Reset in the second access cycle abandons the read; held REQ re-granted
  task automatic test_reset_abort();
    mem_rdata = 16'h9999;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0400;
    tick(); mid();
    n_checks++;
    if (mem_en !== 1'b1) $display("FAIL rst_c1: en=%b exp 1", mem_en);
    else n_pass++;
    tick(); rst = 1'b1; #1;
    n_checks++;
    if ({mem_en, busy} !== 2'b00) $display("FAIL rst_async: en/busy=%b%b exp 00", mem_en, busy);
    else n_pass++;
    mid();
    n_checks++;
    if ({rdata, mem_addr} !== 32'h0) $display("FAIL rst_regs: rdata=%h addr=%h exp 0000 0000", rdata, mem_addr);
    else n_pass++;
    tick(); rst = 1'b0;
    sb1.push_back('{dbg: 1'b0, rdata: 16'h9999});
    mid();
    n_checks++;
    if ({cpu_ack, mem_en} !== 2'b00) $display("FAIL rst_c3: ack/en=%b%b exp 00", cpu_ack, mem_en);
    else n_pass++;
    tick(); mid();
    n_checks++;
    if ({mem_en, mem_addr} !== {1'b1, 16'h0400}) $display("FAIL rst_regrant: en=%b addr=%h exp 1 0400", mem_en, mem_addr);
    else n_pass++;
    tick(); tick(); cpu_req = 1'b0; mid();
    n_checks++;
    if (cpu_ack !== 1'b1) $display("FAIL rst_ack: ack=%b exp 1", cpu_ack);
    else n_pass++;
  endtask

  // WAIT_STATES=0 debug read: one access cycle, ACK in cycle 2
  task automatic test_ws0();
    mem_rdata = 16'h6006;
    tick();
    dbg_req0 = 1'b1; dbg_addr0 = 16'h0500;
    sb0.push_back('{dbg: 1'b1, rdata: 16'h6006});
    tick(); mid();
    n_checks++;
    if ({mem_en0, mem_we0, busy0, mem_addr0} !== {3'b101, 16'h0500})
      $display("FAIL ws0_c1: en/we/busy=%b%b%b addr=%h exp 101 0500", mem_en0, mem_we0, busy0, mem_addr0);
    else n_pass++;
    tick(); dbg_req0 = 1'b0; mid();
    n_checks++;
    if ({dbg_ack0, mem_en0, rdata0} !== {2'b10, 16'h6006})
      $display("FAIL ws0_c2: ack/en=%b%b rdata=%h exp 10 6006", dbg_ack0, mem_en0, rdata0);
    else n_pass++;
    tick(); mid();
    n_checks++;
    if ({dbg_ack0, mem_en0} !== 2'b00) $display("FAIL ws0_c3: ack/en=%b%b exp 00", dbg_ack0, mem_en0);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = 16'hC0C0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    dbg_mode = 1'b0; mem_rdata = '0;
    zero1 = 1'b0; zero16 = '0; dbg_req0 = 1'b0; dbg_addr0 = '0;

    test_reset();
    test_cpu_read();
    test_back_to_back();
    test_debug_mode();
    test_drop_req();
    test_reset_abort();
    test_ws0();

    tick(); tick(); mid();
    n_checks++;
    if (sb1.size() != 0 || sb0.size() != 0)
      $display("FAIL sb_drain: %0d/%0d completions never acknowledged", sb1.size(), sb0.size());
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
